// File: rtl/seg_execute_alu_issue.sv
// Execute-stage ALU issuer: decodes ALUOp/funct, registers operands in ID/EX and captures the ALU result in EX/MEM.
// Optional macro ALU_ISSUE_NOR_EN adds the nor function (funct 100111 -> 1100).
module seg_execute_alu_issue #(
    parameter int NB_DATA   = 32,
    parameter int NB_ALUCTL = 4,
    parameter int NB_CNT    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [1:0]           i_ALUOp,
    input  logic [5:0]           i_funct,
    input  logic                 i_ALUSrc,
    input  logic                 i_branch,
    input  logic [NB_DATA-1:0]   i_rs_data,
    input  logic [NB_DATA-1:0]   i_rt_data,
    input  logic [NB_DATA-1:0]   i_imm,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [NB_DATA-1:0]   i_ALUOut,
    input  logic                 i_zero,
    output logic [NB_ALUCTL-1:0] o_ALUctl,
    output logic [NB_DATA-1:0]   o_data_a,
    output logic [NB_DATA-1:0]   o_data_b,
    output logic                 o_ex_valid,
    output logic                 o_illegal,
    output logic [NB_DATA-1:0]   o_mem_result,
    output logic                 o_mem_zero,
    output logic                 o_mem_valid,
    output logic                 o_branch_taken,
    output logic [NB_CNT-1:0]    o_issue_cnt
);

    localparam logic [NB_ALUCTL-1:0] CTL_AND = NB_ALUCTL'(4'b0000);
    localparam logic [NB_ALUCTL-1:0] CTL_OR  = NB_ALUCTL'(4'b0001);
    localparam logic [NB_ALUCTL-1:0] CTL_ADD = NB_ALUCTL'(4'b0010);
    localparam logic [NB_ALUCTL-1:0] CTL_SUB = NB_ALUCTL'(4'b0110);
    localparam logic [NB_ALUCTL-1:0] CTL_SLT = NB_ALUCTL'(4'b0111);
`ifdef ALU_ISSUE_NOR_EN
    localparam logic [NB_ALUCTL-1:0] CTL_NOR = NB_ALUCTL'(4'b1100);
`endif

    typedef struct packed {
        logic                 valid;
        logic                 illegal;
        logic                 branch;
        logic [NB_ALUCTL-1:0] ctl;
        logic [NB_DATA-1:0]   a;
        logic [NB_DATA-1:0]   b;
    } idex_t;

    logic [NB_ALUCTL-1:0] w_ctl;
    logic                 w_illegal;
    idex_t                w_idex_nxt;
    idex_t                r_idex;
    logic [NB_DATA-1:0]   r_mem_result;
    logic                 r_mem_zero;
    logic                 r_mem_valid;
    logic                 r_branch_taken;
    logic [NB_CNT-1:0]    r_cnt;

    // Illegal encodings fall back to add so the ALU still sees a defined code.
    always_comb begin
        w_ctl     = CTL_ADD;
        w_illegal = 1'b0;
        case (i_ALUOp)
            2'b00: w_ctl = CTL_ADD;
            2'b01: w_ctl = CTL_SUB;
            2'b10: begin
                case (i_funct)
                    6'b100000: w_ctl = CTL_ADD;
                    6'b100010: w_ctl = CTL_SUB;
                    6'b100100: w_ctl = CTL_AND;
                    6'b100101: w_ctl = CTL_OR;
                    6'b101010: w_ctl = CTL_SLT;
`ifdef ALU_ISSUE_NOR_EN
                    6'b100111: w_ctl = CTL_NOR;
`endif
                    default:   w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_idex_nxt.valid   = i_valid;
        w_idex_nxt.illegal = w_illegal;
        w_idex_nxt.branch  = i_branch;
        w_idex_nxt.ctl     = w_ctl;
        w_idex_nxt.a       = i_rs_data;
        w_idex_nxt.b       = i_ALUSrc ? i_imm : i_rt_data;
    end

    // Flush outranks stall: a bubble goes in even while the pipe is frozen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idex <= '0;
        end else if (i_flush) begin
            r_idex.valid   <= 1'b0;
            r_idex.illegal <= 1'b0;
            r_idex.branch  <= 1'b0;
        end else if (!i_stall) begin
            r_idex <= w_idex_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_result   <= '0;
            r_mem_zero     <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_branch_taken <= 1'b0;
        end else if (!i_stall) begin
            r_mem_result   <= i_ALUOut;
            r_mem_zero     <= i_zero;
            r_mem_valid    <= r_idex.valid;
            r_branch_taken <= r_idex.valid & r_idex.branch & i_zero;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_valid && !i_stall && !i_flush) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_ALUctl       = r_idex.ctl;
    assign o_data_a       = r_idex.a;
    assign o_data_b       = r_idex.b;
    assign o_ex_valid     = r_idex.valid;
    assign o_illegal      = r_idex.illegal;
    assign o_mem_result   = r_mem_result;
    assign o_mem_zero     = r_mem_zero;
    assign o_mem_valid    = r_mem_valid;
    assign o_branch_taken = r_branch_taken;
    assign o_issue_cnt    = r_cnt;

endmodule

// File: tb/tb_seg_execute_alu_issue.sv
// Bench for seg_execute_alu_issue: ALU loopback, spec-level reference model checked every cycle, directed literals.
module tb_seg_execute_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, src = 1'b0, br = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [5:0]  fn = 6'b0;
    logic [31:0] rs = '0, rt = '0, imm = '0;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [3:0]  o_ctl;
    logic [31:0] o_a, o_b, o_res;
    logic        o_exv, o_ill, o_mz, o_mv, o_tk;
    logic [3:0]  o_cnt;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg_execute_alu_issue #(.NB_DATA(32), .NB_ALUCTL(4), .NB_CNT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_ALUOp(op), .i_funct(fn),
        .i_ALUSrc(src), .i_branch(br), .i_rs_data(rs), .i_rt_data(rt), .i_imm(imm),
        .i_stall(stall), .i_flush(flush), .i_ALUOut(alu_out), .i_zero(alu_zero),
        .o_ALUctl(o_ctl), .o_data_a(o_a), .o_data_b(o_b), .o_ex_valid(o_exv),
        .o_illegal(o_ill), .o_mem_result(o_res), .o_mem_zero(o_mz), .o_mem_valid(o_mv),
        .o_branch_taken(o_tk), .o_issue_cnt(o_cnt)
    );

    function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return {31'b0, $signed(a) < $signed(b)};
            4'b1100: return ~(a | b);
            default: return 32'b0;
        endcase
    endfunction

    // Returns {code, illegal} straight from the decode table.
    function automatic logic [4:0] decode(input logic [1:0] o, input logic [5:0] f);
        if (o == 2'b00) return {4'b0010, 1'b0};
        if (o == 2'b01) return {4'b0110, 1'b0};
        if (o == 2'b11) return {4'b0010, 1'b1};
        case (f)
            6'b100000: return {4'b0010, 1'b0};
            6'b100010: return {4'b0110, 1'b0};
            6'b100100: return {4'b0000, 1'b0};
            6'b100101: return {4'b0001, 1'b0};
            6'b101010: return {4'b0111, 1'b0};
`ifdef ALU_ISSUE_NOR_EN
            6'b100111: return {4'b1100, 1'b0};
`endif
            default:   return {4'b0010, 1'b1};
        endcase
    endfunction

    assign alu_out  = alu(o_ctl, o_a, o_b);
    assign alu_zero = (alu_out == 32'b0);

    // Reference model
    logic        m_exv = 0, m_ill = 0, m_br = 0, m_mz = 0, m_mv = 0, m_tk = 0;
    logic [3:0]  m_ctl = '0, m_cnt = '0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_exv <= 0; m_ill <= 0; m_br <= 0; m_ctl <= '0; m_a <= '0; m_b <= '0;
            m_res <= '0; m_mz <= 0; m_mv <= 0; m_tk <= 0; m_cnt <= '0;
        end else begin
            if (flush) begin
                m_exv <= 0; m_ill <= 0; m_br <= 0;
            end else if (!stall) begin
                m_exv <= valid;
                {m_ctl, m_ill} <= decode(op, fn);
                m_br <= br;
                m_a <= rs;
                m_b <= src ? imm : rt;
            end
            if (!stall) begin
                m_res <= alu(m_ctl, m_a, m_b);
                m_mz  <= (alu(m_ctl, m_a, m_b) == 0);
                m_mv  <= m_exv;
                m_tk  <= m_exv & m_br & (alu(m_ctl, m_a, m_b) == 0);
            end
            if (valid && !stall && !flush) m_cnt <= m_cnt + 4'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        else passed++;
    endtask

    always @(negedge clk) begin
        chk("m.ctl", {28'b0, o_ctl}, {28'b0, m_ctl});
        chk("m.a", o_a, m_a);
        chk("m.b", o_b, m_b);
        chk("m.flags", {26'b0, o_exv, o_ill, o_mz, o_mv, o_tk, 1'b0}, {26'b0, m_exv, m_ill, m_mz, m_mv, m_tk, 1'b0});
        chk("m.res", o_res, m_res);
        chk("m.cnt", {28'b0, o_cnt}, {28'b0, m_cnt});
    end

    task automatic drive(input logic v, input logic [1:0] o, input logic [5:0] f, input logic s,
                         input logic b, input logic [31:0] a, input logic [31:0] t, input logic [31:0] im,
                         input logic st, input logic fl);
        valid = v; op = o; fn = f; src = s; br = b; rs = a; rt = t; imm = im; stall = st; flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(0, 2'b00, 6'b0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {o_ctl, o_a[7:0], o_b[7:0], o_exv, o_ill, o_mz, o_mv, o_tk, o_cnt, o_res[6:0]}, 32'b0);
        chk({nm, ".hi"}, o_a | o_b | o_res, 32'b0);
    endtask

    logic [1:0]  sw_op [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    logic [5:0]  sw_fn [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h00};
    logic [3:0]  sw_ex [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b0010, 4'b0110};

    initial begin
        // Reset held 3 cycles
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk_zero("reset");

        for (int i = 0; i < 7; i++) begin
            drive(1, sw_op[i], sw_fn[i], 0, 0, 32'd10, 32'd4, 0, 0, 0);
            chk($sformatf("sweep%0d.ctl", i), {28'b0, o_ctl}, {28'b0, sw_ex[i]});
            chk($sformatf("sweep%0d.ill", i), {31'b0, o_ill}, 32'd0);
        end
        drive(1, 2'b11, 6'h20, 0, 0, 1, 1, 0, 0, 0);
        chk("op11.ctl", {28'b0, o_ctl}, 32'b0010);
        chk("op11.ill", {31'b0, o_ill}, 32'd1);
        drive(1, 2'b10, 6'h00, 0, 0, 1, 1, 0, 0, 0);
        chk("badfn.ill", {31'b0, o_ill}, 32'd1);
        drive(1, 2'b10, 6'h27, 0, 0, 1, 1, 0, 0, 0);
`ifdef ALU_ISSUE_NOR_EN
        chk("nor.ctl", {28'b0, o_ctl}, 32'b1100);
        chk("nor.ill", {31'b0, o_ill}, 32'd0);
`else
        chk("nor.ctl", {28'b0, o_ctl}, 32'b0010);
        chk("nor.ill", {31'b0, o_ill}, 32'd1);
`endif

        // Result return: 5 - 3
        drive(1, 2'b01, 6'h0, 0, 0, 32'd5, 32'd3, 0, 0, 0);
        idle();
        chk("sub.res", o_res, 32'd2);
        chk("sub.mv", {31'b0, o_mv}, 32'd1);
        drive(1, 2'b00, 6'h0, 1, 0, 32'd9, 32'd3, 32'hFFFF_FFFF, 0, 0);
        chk("imm.b", o_b, 32'hFFFF_FFFF);
        idle();
        chk("imm.res", o_res, 32'd8);

        // Branch
        drive(1, 2'b01, 6'h0, 0, 1, 32'd7, 32'd7, 0, 0, 0);
        idle();
        chk("beq.eq", {31'b0, o_tk}, 32'd1);
        drive(1, 2'b01, 6'h0, 0, 1, 32'd7, 32'd8, 0, 0, 0);
        idle();
        chk("beq.ne", {31'b0, o_tk}, 32'd0);
        drive(1, 2'b01, 6'h0, 0, 1, 32'd7, 32'd7, 0, 0, 1);
        chk("beq.fl.exv", {31'b0, o_exv}, 32'd0);
        idle();
        chk("beq.fl.tk", {31'b0, o_tk}, 32'd0);

        // Stall 3 cycles mid-stream
        drive(1, 2'b00, 6'h0, 0, 0, 32'd1, 32'd1, 0, 0, 0);
        drive(1, 2'b00, 6'h0, 0, 0, 32'd2, 32'd2, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 6'h0, 0, 0, 32'd3, 32'd3, 0, 1, 0);
            chk("stall.a", o_a, 32'd2);
            chk("stall.res", o_res, 32'd2);
        end
        drive(1, 2'b00, 6'h0, 0, 0, 32'd3, 32'd3, 0, 0, 0);
        chk("post.a", o_a, 32'd3);
        chk("post.res", o_res, 32'd4);
        idle();
        chk("post.res2", o_res, 32'd6);

        // Stall and flush together
        drive(1, 2'b00, 6'h0, 0, 0, 32'd4, 32'd4, 0, 0, 0);
        drive(1, 2'b00, 6'h0, 0, 0, 32'd5, 32'd5, 0, 0, 0);
        drive(1, 2'b00, 6'h0, 0, 0, 32'd6, 32'd6, 0, 1, 1);
        chk("sf.exv", {31'b0, o_exv}, 32'd0);
        chk("sf.res", o_res, 32'd8);
        chk("sf.mv", {31'b0, o_mv}, 32'd1);
        idle();
        chk("sf.bubble", {31'b0, o_mv}, 32'd0);

        // Counter wrap from a fresh reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 17; i++) drive(1, 2'b00, 6'h0, 0, 0, i, 1, 0, 0, 0);
        chk("cnt.wrap", {28'b0, o_cnt}, 32'd1);

        // Async reset mid-stream
        drive(1, 2'b00, 6'h0, 0, 0, 32'd7, 32'd1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_zero("async");
        valid = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        idle();
        chk("async.mv", {31'b0, o_mv}, 32'd0);
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_execute_alu_issue.md
# seg_execute_alu_issue

Execute-stage command issuer and result collector for the MIPS pipeline ALU (`seg_execute_alu`). It accepts decoded ID-stage fields, translates ALUOp/funct into the 4-bit ALU control code, and registers the ALU operands in an ID/EX stage that drives the ALU. One cycle later it captures the ALU result and zero flag, plus the branch decision, in an EX/MEM stage. Stall and flush are supported, and a wrapping issue counter is provided for debug.

## Interface
- `NB_DATA`, default 32: operand and result width.
- `NB_ALUCTL`, default 4: ALU control code width.
- `NB_CNT`, default 16: issue counter width.
- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_valid` in 1: ID-stage command present.
- `i_ALUOp` in 2: 00 = add (load/store), 01 = sub (beq), 10 = R-type (decoded from funct), 11 = illegal.
- `i_funct` in 6: R-type function field.
- `i_ALUSrc` in 1: 1 selects `i_imm` as operand B, 0 selects `i_rt_data`.
- `i_branch` in 1: command is a beq.
- `i_rs_data` in NB_DATA: operand A.
- `i_rt_data` in NB_DATA: register operand B.
- `i_imm` in NB_DATA: immediate, already sign-extended upstream.
- `i_stall` in 1: hold both stages.
- `i_flush` in 1: insert a bubble into ID/EX.
- `i_ALUOut` in NB_DATA: result returned from the ALU.
- `i_zero` in 1: zero flag returned from the ALU.
- `o_ALUctl` out NB_ALUCTL: registered control code to the ALU.
- `o_data_a` out NB_DATA: registered operand A to the ALU.
- `o_data_b` out NB_DATA: registered operand B to the ALU.
- `o_ex_valid` out 1: ID/EX holds a live command.
- `o_illegal` out 1: the live ID/EX command had an illegal ALUOp/funct.
- `o_mem_result` out NB_DATA: captured ALU result.
- `o_mem_zero` out 1: captured zero flag.
- `o_mem_valid` out 1: EX/MEM holds a live result.
- `o_branch_taken` out 1: registered branch decision; equals branch & zero & valid.
- `o_issue_cnt` out NB_CNT: count of commands accepted into ID/EX.

## Operation
- Decode:
  - ALUOp 00 → 0010.
  - ALUOp 01 → 0110.
  - ALUOp 10, by funct:
    - 100000 → 0010 (add)
    - 100010 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 101010 → 0111 (slt)
  - Any other funct, or ALUOp 11 → code 0010, and the command is flagged illegal.
- Illegal commands still issue. `o_illegal` travels with the command, and the downstream trap logic acts on it.
- ID/EX update, in priority order:
  - reset
  - flush: clears `o_ex_valid`, `o_illegal` and the branch bit; data fields keep their values
  - stall: holds all fields
  - otherwise load: `o_ex_valid` ← `i_valid`, and all other fields are loaded
- When `i_valid` = 0 and the stage is not stalled, the data fields still load (don't care) and `o_ex_valid` = 0.
- EX/MEM update:
  - reset: clear.
  - stall: hold.
  - otherwise: capture `i_ALUOut` and `i_zero`; `o_mem_valid` ← `o_ex_valid`; `o_branch_taken` ← `o_ex_valid` & branch & `i_zero`.
- Flush does not affect EX/MEM.
- `o_issue_cnt` increments by 1 on every edge where ID/EX loads with `i_valid` = 1 and there is no stall or flush. It wraps from 2^NB_CNT−1 to 0.
- Simultaneous flush and stall: flush wins. The ID/EX bubble is inserted and EX/MEM holds.

## Timing
- Reset (async assert, synchronous-to-clock release): every output = 0, including `o_ALUctl` = 0000 and `o_issue_cnt` = 0.
- Reset asserted mid-operation: in-flight commands are discarded immediately; no result is captured for them.
- Latency:
  - Command presented at edge n: it is visible on `o_ALUctl`/`o_data_*` after edge n.
  - The ALU is combinational, so the result appears on `o_mem_*` after edge n+1.
  - Issue-to-result latency is 2 cycles.
- Throughput: one command per cycle when not stalled.
- A stall of k cycles delays every in-flight command by exactly k cycles; no command is lost or duplicated.

## Configuration
- `ALU_ISSUE_NOR_EN` defined:
  - funct 100111 decodes to 1100 (nor) and is legal.
  - Test scenario 2 additionally issues funct 100111 and expects `o_ALUctl` = 1100, `o_illegal` = 0.
- Undefined: funct 100111 is illegal, with code 0010 and `o_illegal` = 1.

## Test plan
- **Reset:** hold `i_rst_n` = 0 for 3 cycles, then release → all outputs are 0. Assert reset asynchronously mid-stream → outputs clear before the next edge.
- **Decode sweep:** ALUOp = 10 with funct 100000/100010/100100/100101/101010, then ALUOp 00 and 01 → `o_ALUctl` = 0010/0110/0000/0001/0111/0010/0110 on consecutive cycles with `o_illegal` = 0. Then ALUOp 11 → 0010 with `o_illegal` = 1.
- **Result return:** `i_rs_data` = 5, `i_rt_data` = 3, sub; loop the ALU back with a model → `o_mem_result` = 2 and `o_mem_valid` = 1 two cycles after issue. Set `i_ALUSrc` = 1, `i_imm` = −1, add → `o_data_b` = all ones.
- **Branch:** beq with `i_rs_data` = `i_rt_data` = 7 → `o_branch_taken` = 1 one cycle after the ID/EX load. With 7 vs 8 → `o_branch_taken` = 0. The same beq issued with `i_flush` = 1 → never taken.
- **Stall/flush collision:**
  - Stall for 3 cycles mid-stream → the outputs hold and no command is lost.
  - Assert `i_stall` and `i_flush` together → `o_ex_valid` = 0, EX/MEM holds, and `o_issue_cnt` does not change.
- **Counter wrap:** NB_CNT = 4, issue 17 valid commands → `o_issue_cnt` = 1.
